matmul_engine: RTL



---
 rtl/matmul_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/matmul_engine.sv
// matmul_engine: weight-stationary Y = W*X engine with handshake, signed mode and saturation
module matmul_engine #(
  parameter int N = 5,
  parameter int K = 5,
  parameter int T = 10,
  parameter int DW = 8,
  parameter int OW = 8,
  parameter int SIGNED = 0,
  parameter int AW = 2*DW+$clog2(K)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            SAT,
  input  logic            W_VAL,
  input  logic [K*DW-1:0] W_DATA,
  input  logic            IN_VAL,
  output logic            IN_RDY,
  input  logic [K*DW-1:0] IN_DATA,
  output logic            OUT_VAL,
  output logic [N*OW-1:0] OUT_DATA,
  output logic [N-1:0]    OUT_OV,
  output logic            BUSY,
  output logic            DONE
);
  localparam int WCW = $clog2(N+1);
  localparam int VCW = $clog2(T+1);

  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;

  state_t state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [VCW-1:0] vcnt_q, vcnt_d;
  logic dcnt_q, dcnt_d;
  logic sat_q, sat_d;
  logic done_d, done_q;
  logic [K*DW-1:0] w_q [N];
  logic [K*DW-1:0] x_q;
  logic v0_q, v1_q;
  logic [2*DW-1:0] prod_q [N][K];
  logic out_val_q;
  logic [N*OW-1:0] out_q, conv;
  logic [N-1:0] ov_q, ov;
  logic [AW-1:0] acc;
  logic [OW-1:0] lim;
  logic accept;

  function automatic logic [2*DW-1:0] ext_d(input logic [DW-1:0] v);
    logic signed [2*DW-1:0] s;
    s = $signed(v);
    return (SIGNED != 0) ? s : {{DW{1'b0}}, v};
  endfunction

  function automatic logic [AW-1:0] ext_p(input logic [2*DW-1:0] p);
    logic signed [AW-1:0] s;
    s = $signed(p);
    return (SIGNED != 0) ? s : AW'(p);
  endfunction

  assign IN_RDY = state_q == RUN;
  assign BUSY = state_q != IDLE;
  assign accept = IN_VAL && IN_RDY;
  assign OUT_VAL = out_val_q;
  assign OUT_DATA = out_q;
  assign OUT_OV = ov_q;
  assign DONE = done_q;

  // Job sequencing: weight load, vector streaming, then a two-cycle drain
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    vcnt_d = vcnt_q;
    dcnt_d = dcnt_q;
    sat_d = sat_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        state_d = LOAD_W;
        sat_d = SAT;
        wcnt_d = '0;
        vcnt_d = '0;
      end
      LOAD_W: if (W_VAL) begin
        wcnt_d = wcnt_q + 1'b1;
        state_d = (wcnt_q == WCW'(N-1)) ? RUN : LOAD_W;
      end
      RUN: if (IN_VAL) begin
        vcnt_d = vcnt_q + 1'b1;
        dcnt_d = 1'b0;
        state_d = (vcnt_q == VCW'(T-1)) ? DRAIN : RUN;
      end
      DRAIN: begin
        dcnt_d = 1'b1;
        state_d = dcnt_q ? IDLE : DRAIN;
        done_d = dcnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      vcnt_q <= '0;
      dcnt_q <= 1'b0;
      sat_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      vcnt_q <= vcnt_d;
      dcnt_q <= dcnt_d;
      sat_q <= sat_d;
      done_q <= done_d;
    end
  end

  // Weight rows are written in arrival order and kept until the next load
  always_ff @(posedge CLK) begin
    for (int n = 0; n < N; n++)
      if (state_q == LOAD_W && W_VAL && wcnt_q == WCW'(n)) w_q[n] <= W_DATA;
  end

  // Input capture and stage-1 products against the stationary weights
  always_ff @(posedge CLK) begin
    if (accept) x_q <= IN_DATA;
    for (int n = 0; n < N; n++)
      for (int k = 0; k < K; k++)
        prod_q[n][k] <= ext_d(w_q[n][k*DW +: DW]) * ext_d(x_q[k*DW +: DW]);
  end

  // Full-precision reduction per lane, then range check and saturate or wrap
  always_comb begin
    conv = '0;
    ov = '0;
    acc = '0;
    lim = '0;
    for (int n = 0; n < N; n++) begin
      acc = '0;
      for (int k = 0; k < K; k++) acc = acc + ext_p(prod_q[n][k]);
      ov[n] = (SIGNED != 0) ? !(&acc[AW-1:OW-1] || ~|acc[AW-1:OW-1]) : |acc[AW-1:OW];
      lim = (SIGNED != 0) ? (acc[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}}) : '1;
      conv[n*OW +: OW] = (sat_q && ov[n]) ? lim : acc[OW-1:0];
    end
  end

  // Pipeline valids and output registers; reset discards anything in flight
  always_ff @(posedge CLK) begin
    if (RST) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      out_val_q <= 1'b0;
      out_q <= '0;
      ov_q <= '0;
    end else begin
      v0_q <= accept;
      v1_q <= v0_q;
      out_val_q <= v1_q;
      if (v1_q) begin
        out_q <= conv;
        ov_q <= ov;
      end
    end
  end
endmodule
